// File: rtl/pkg_cpu.sv
// pkg_cpu: shared widths, access-size codes, opcode and state encodings for spcpu
package pkg_cpu;
    localparam int DW = 16;
    localparam int NREG = 16;
    localparam logic cpu_data_acc_sz_8 = 1'b0;
    localparam logic cpu_data_acc_sz_16 = 1'b1;
    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LSR, OP_LDI, OP_LUI,
        OP_LDW, OP_STW, OP_LDB, OP_STB, OP_BZ, OP_JMP, OP_SYS, OP_HALT
    } opcode_t;
    typedef enum logic [2:0] {FETCH_REQ, FETCH_WAIT, EXEC, MEM_REQ, MEM_WAIT, HALT} state_t;
endpackage

// File: rtl/spcpu_alu.sv
// spcpu_alu: combinational two-operand ALU for the register-register opcodes
module spcpu_alu
    import pkg_cpu::*;
(
    input  opcode_t       op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);
    always_comb
        y = op == OP_ADD ? a + b :
            op == OP_SUB ? a - b :
            op == OP_AND ? a & b :
            op == OP_OR  ? a | b :
            op == OP_XOR ? a ^ b :
                           a >> b[3:0];
endmodule

// File: rtl/spcpu.sv
// spcpu: 16-bit multi-cycle CPU with a request/ready memory port and one level interrupt
module spcpu
    import pkg_cpu::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] INT_VECTOR = 16'h0010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    input  logic        data_ready,
    input  logic [15:0] temp_data_in,
    output logic [15:0] temp_data_out,
    output logic [15:0] data_inout_addr,
    output logic        data_acc_sz,
    output logic        data_inout_we,
    output logic        req_rdwr,
    output logic [15:0] debug_vec
);
    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] pc, ir, spc, va, vb, alu_y;
    logic ie, irq_take, fetching, mem_phase, mem_wide, mem_store;
    logic [3:0] ra, rb;
    logic [7:0] imm;
    opcode_t op;
    state_t state, state_n;

    assign op = opcode_t'(ir[15:12]);
    assign ra = ir[11:8];
    assign rb = ir[7:4];
    assign imm = ir[7:0];
    assign va = regs[ra];
    assign vb = regs[rb];
    assign mem_wide = !ir[13];
    assign mem_store = ir[12];
    assign irq_take = state == FETCH_REQ && ie && interrupt;
    assign fetching = state == FETCH_REQ || state == FETCH_WAIT;
    assign mem_phase = state == MEM_REQ || state == MEM_WAIT;
    assign debug_vec = regs[0];

    spcpu_alu alu (.op(op), .a(va), .b(vb), .y(alu_y));

    // bus outputs derive from state and registers that cannot change until the wait completes
    always_comb begin
        req_rdwr = !reset && ((state == FETCH_REQ && !irq_take) || state == MEM_REQ);
        data_inout_addr = reset ? '0 : fetching ? pc : mem_phase ? {vb[15:1], vb[0] & !mem_wide} : '0;
        data_acc_sz = (reset || !mem_phase) ? cpu_data_acc_sz_16 : (mem_wide ? cpu_data_acc_sz_16 : cpu_data_acc_sz_8);
        data_inout_we = !reset && mem_phase && mem_store;
        temp_data_out = data_inout_we ? va : '0;
    end

    always_comb begin
        state_n = state;
        case (state)
            FETCH_REQ:  state_n = irq_take ? FETCH_REQ : FETCH_WAIT;
            FETCH_WAIT: state_n = data_ready ? EXEC : FETCH_WAIT;
            EXEC:       state_n = ir[15:14] == 2'b10 ? MEM_REQ : op == OP_HALT ? HALT : FETCH_REQ;
            MEM_REQ:    state_n = MEM_WAIT;
            MEM_WAIT:   state_n = data_ready ? FETCH_REQ : MEM_WAIT;
            HALT:       state_n = HALT;
            default:    state_n = FETCH_REQ;
        endcase
    end

    always_ff @(posedge clk)
        state <= reset ? FETCH_REQ : state_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
            ir <= '0;
            spc <= '0;
            ie <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                FETCH_REQ: if (irq_take) begin
                    spc <= pc;
                    ie <= 1'b0;
                    pc <= INT_VECTOR;
                end
                FETCH_WAIT: if (data_ready) begin
                    ir <= temp_data_in;
                    pc <= pc + 16'd2;
                end
                EXEC: case (op)
                    OP_LDI:  regs[ra] <= {8'h00, imm};
                    OP_LUI:  regs[ra] <= {imm, va[7:0]};
                    OP_BZ:   if (va == '0) pc <= pc + {{7{imm[7]}}, imm, 1'b0};
                    OP_JMP:  pc <= va;
                    OP_SYS: begin
                        ie <= imm[1:0] == 2'd0 ? 1'b0 : imm[1:0] == 2'd3 ? ie : 1'b1;
                        pc <= imm[1:0] == 2'd2 ? spc : pc;
                    end
                    default: if (op <= OP_LSR) regs[ra] <= alu_y;
                endcase
                MEM_WAIT: if (data_ready && !mem_store)
                    regs[ra] <= mem_wide ? temp_data_in : {8'h00, temp_data_in[7:0]};
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spcpu.sv
// tb_spcpu: ISA-level reference model feeding a bus-transaction scoreboard for spcpu
module tb_spcpu;
    logic clk = 1'b0, reset = 1'b1, interrupt = 1'b0, data_ready = 1'b0;
    logic [15:0] temp_data_in = '0;
    logic [15:0] temp_data_out, data_inout_addr, debug_vec;
    logic data_acc_sz, data_inout_we, req_rdwr;

    always #5 clk = ~clk;

    spcpu dut (
        .clk(clk), .reset(reset), .interrupt(interrupt), .data_ready(data_ready),
        .temp_data_in(temp_data_in), .temp_data_out(temp_data_out),
        .data_inout_addr(data_inout_addr), .data_acc_sz(data_acc_sz),
        .data_inout_we(data_inout_we), .req_rdwr(req_rdwr), .debug_vec(debug_vec)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic        we;
        logic        sz;
        logic [15:0] wd;
        logic [15:0] r0;
    } txn_t;

    txn_t exp_q[$];
    int total = 0, bad = 0;
    bit stall_wr = 0, allow_extra = 0;
    logic [7:0] mem [0:65535];
    logic [7:0] m_mem [0:65535];
    logic [15:0] m_r [16];
    logic [15:0] m_pc, m_spc;
    logic m_ie;
    logic [15:0] r_a, r_d;
    logic r_w, r_s;
    int r_lat;
    txn_t act, e;

    task automatic chk(input string n, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, got, want);
        end
    endtask

    task automatic put(input logic [15:0] a, input logic [15:0] w);
        mem[a] = w[7:0];
        mem[a + 16'd1] = w[15:8];
        m_mem[a] = w[7:0];
        m_mem[a + 16'd1] = w[15:8];
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'h00;
            m_mem[i] = 8'h00;
        end
    endtask

    // instruction-level interpreter: one loop iteration per instruction, bus traffic as a list
    task automatic model_run(input int max_tx);
        int n = 0;
        bit halted = 0, wide, st;
        logic [15:0] ir, a, va, vb;
        logic [3:0] op, ra, rb;
        logic [7:0] imm;
        m_pc = 16'h0000; m_spc = 16'h0000; m_ie = 1'b0;
        for (int i = 0; i < 16; i++) m_r[i] = 16'h0000;
        while (n < max_tx && !halted) begin
            if (m_ie && interrupt) begin
                m_spc = m_pc;
                m_ie = 1'b0;
                m_pc = 16'h0010;
                continue;
            end
            exp_q.push_back(txn_t'{m_pc, 1'b0, 1'b1, 16'h0000, m_r[0]});
            n++;
            a = m_pc + 16'd1;
            ir = {m_mem[a], m_mem[m_pc]};
            m_pc = m_pc + 16'd2;
            op = ir[15:12]; ra = ir[11:8]; rb = ir[7:4]; imm = ir[7:0];
            va = m_r[ra]; vb = m_r[rb];
            if (op >= 4'd8 && op <= 4'd11) begin
                if (n >= max_tx) break;
                wide = op == 4'd8 || op == 4'd9;
                st = op == 4'd9 || op == 4'd11;
                a = wide ? (vb & 16'hFFFE) : vb;
                exp_q.push_back(txn_t'{a, st, wide, st ? (wide ? va : {8'h00, va[7:0]}) : 16'h0000, m_r[0]});
                n++;
                if (st) begin
                    m_mem[a] = va[7:0];
                    if (wide) m_mem[a + 16'd1] = va[15:8];
                end else
                    m_r[ra] = wide ? {m_mem[a + 16'd1], m_mem[a]} : {8'h00, m_mem[a]};
            end else begin
                case (op)
                    4'd0: m_r[ra] = va + vb;
                    4'd1: m_r[ra] = va - vb;
                    4'd2: m_r[ra] = va & vb;
                    4'd3: m_r[ra] = va | vb;
                    4'd4: m_r[ra] = va ^ vb;
                    4'd5: m_r[ra] = va >> vb[3:0];
                    4'd6: m_r[ra] = {8'h00, imm};
                    4'd7: m_r[ra] = {imm, va[7:0]};
                    4'd12: if (va == 16'h0000) m_pc = m_pc + {{8{imm[7]}}, imm} * 16'd2;
                    4'd13: m_pc = va;
                    4'd14: case (imm[1:0])
                        2'd0: m_ie = 1'b0;
                        2'd1: m_ie = 1'b1;
                        2'd2: begin m_pc = m_spc; m_ie = 1'b1; end
                        default: ;
                    endcase
                    default: halted = 1;
                endcase
            end
        end
    endtask

    // memory responder: random latency, spurious ready in the request cycle, hold check at completion
    initial begin
        forever begin
            @(negedge clk);
            data_ready = 1'b0;
            if (!reset && req_rdwr) begin
                r_a = data_inout_addr; r_w = data_inout_we; r_s = data_acc_sz; r_d = temp_data_out;
                if ($urandom_range(1) == 1) begin
                    data_ready = 1'b1;
                    temp_data_in = 16'($urandom);
                end
                r_lat = (stall_wr && r_w) ? 1000000 : $urandom_range(2);
                @(negedge clk);
                data_ready = 1'b0;
                for (int i = 0; i < r_lat && !reset; i++) @(negedge clk);
                if (!reset) begin
                    total++;
                    if ({data_inout_addr, data_inout_we, data_acc_sz, temp_data_out} !== {r_a, r_w, r_s, r_d}) begin
                        bad++;
                        $display("FAIL bus_hold got=%h/%b/%b/%h want=%h/%b/%b/%h", data_inout_addr,
                                 data_inout_we, data_acc_sz, temp_data_out, r_a, r_w, r_s, r_d);
                    end
                    if (r_w) begin
                        mem[r_a] = r_d[7:0];
                        if (r_s) mem[r_a + 16'd1] = r_d[15:8];
                    end else
                        temp_data_in = r_s ? {mem[r_a + 16'd1], mem[r_a]} : {8'($urandom), mem[r_a]};
                    data_ready = 1'b1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset && req_rdwr) begin
                act = txn_t'{data_inout_addr, data_inout_we, data_acc_sz,
                             data_inout_we ? (data_acc_sz ? temp_data_out : {8'h00, temp_data_out[7:0]}) : 16'h0000,
                             debug_vec};
                if (exp_q.size() == 0) begin
                    if (!allow_extra) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_req got addr=%h we=%b want no request", data_inout_addr, data_inout_we);
                    end
                end else begin
                    e = exp_q.pop_front();
                    total++;
                    if (act !== e) begin
                        bad++;
                        $display("FAIL txn got addr=%h we=%b sz=%b wd=%h r0=%h want addr=%h we=%b sz=%b wd=%h r0=%h",
                                 act.addr, act.we, act.sz, act.wd, act.r0, e.addr, e.we, e.sz, e.wd, e.r0);
                    end
                end
            end
        end
    end

    task automatic reset_check();
        @(posedge clk);
        #1 reset = 1'b1;
        interrupt = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", {15'd0, req_rdwr}, 16'h0000);
        chk("rst_we", {15'd0, data_inout_we}, 16'h0000);
        chk("rst_sz", {15'd0, data_acc_sz}, 16'h0001);
        chk("rst_addr", data_inout_addr, 16'h0000);
        chk("rst_dout", temp_data_out, 16'h0000);
        chk("rst_r0", debug_vec, 16'h0000);
    endtask

    task automatic run(input int max_tx, input bit halts, input bit irq, input bit stall, input bit loops);
        exp_q.delete();
        stall_wr = stall;
        allow_extra = loops;
        interrupt = irq;
        model_run(max_tx);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 5000 && exp_q.size() != 0; c++) @(negedge clk);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout got left=%0d want 0", exp_q.size());
            exp_q.delete();
        end
        if (halts) begin
            repeat (8) @(negedge clk);
            interrupt = 1'b1;
            repeat (12) @(negedge clk);
            chk("halt_r0", debug_vec, m_r[0]);
        end
        if (stall) repeat (12) @(negedge clk);
    endtask

    task automatic gen_random(input int n_ins);
        logic [15:0] a = 16'h0000;
        int k;
        for (int i = 0; i < n_ins; i++) begin
            k = $urandom_range(9);
            if (k <= 5) begin
                put(a, {4'(k), 4'($urandom), 4'($urandom), 4'($urandom)}); a += 2;
            end else if (k <= 7) begin
                put(a, {4'(k), 4'($urandom), 8'($urandom)}); a += 2;
            end else if (k == 8) begin
                put(a, {8'h6F, 4'h0, 4'($urandom)}); a += 2;
                put(a, 16'h7F80); a += 2;
                put(a, {4'(8 + $urandom_range(3)), 4'($urandom_range(14)), 8'hF0}); a += 2;
            end else begin
                put(a, {14'b1110_0000_0000_00, $urandom_range(2) == 2 ? 2'd3 : 2'($urandom_range(1))}); a += 2;
            end
        end
        put(a, 16'hF000);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        reset_check();
        clear_mem();
        put(16'h0, 16'h6034); put(16'h2, 16'h7012); put(16'h4, 16'hF000);
        run(50, 1, 0, 0, 0);
        chk("ldi_lui", debug_vec, 16'h1234);

        reset_check();
        clear_mem();
        put(16'h0, 16'h6100); put(16'h2, 16'h7101); put(16'h4, 16'h60EF); put(16'h6, 16'h70BE);
        put(16'h8, 16'h9010); put(16'hA, 16'hA210); put(16'hC, 16'h6000); put(16'hE, 16'h3020);
        put(16'h10, 16'hF000);
        run(50, 1, 0, 0, 0);
        chk("stw_mem", {mem[16'h0101], mem[16'h0100]}, 16'hBEEF);
        chk("ldb_zext", debug_vec, 16'h00EF);

        reset_check();
        clear_mem();
        put(16'h0, 16'h60FF); put(16'h2, 16'h70FF); put(16'h4, 16'h6101); put(16'h6, 16'h0010);
        put(16'h8, 16'hC0FF);
        run(14, 0, 0, 0, 1);
        chk("add_wrap", debug_vec, 16'h0000);

        reset_check();
        clear_mem();
        put(16'h0, 16'hE001); put(16'h2, 16'hF000); put(16'h10, 16'h6077); put(16'h12, 16'hE002);
        run(12, 0, 1, 0, 1);
        chk("irq_r0", debug_vec, 16'h0077);

        reset_check();
        clear_mem();
        put(16'h0, 16'h6320); put(16'h2, 16'h6005); put(16'h4, 16'hC004); put(16'h6, 16'hE003);
        put(16'h8, 16'hE001); put(16'hA, 16'hE000); put(16'hC, 16'hD300); put(16'hE, 16'hF000);
        put(16'h20, 16'h6400); put(16'h22, 16'hC401); put(16'h24, 16'h60EE); put(16'h26, 16'h6042);
        put(16'h28, 16'hF000);
        run(50, 1, 0, 0, 0);
        chk("jmp_bz", debug_vec, 16'h0042);

        reset_check();
        clear_mem();
        put(16'h0, 16'h6055); put(16'h2, 16'h6180); put(16'h4, 16'h7180); put(16'h6, 16'h9010);
        put(16'h8, 16'hF000);
        run(5, 0, 0, 1, 0);
        reset_check();
        stall_wr = 0;
        chk("abort_mem", {mem[16'h8081], mem[16'h8080]}, 16'h0000);

        for (int t = 0; t < 8; t++) begin
            reset_check();
            clear_mem();
            gen_random(30);
            run(400, 1, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
